// File: rtl/fp_add_share_pkg.sv
// Shared definitions for the FP adder sharing controller.
//   state_t          controller FSM encoding
//   FP_QNAN          quiet NaN returned when the watchdog aborts an operation
//   DEF_NUM_REQ      default number of requesters
//   DEF_TIMEOUT_CYC  default WAIT-state cycle budget for the watchdog
package fp_add_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] FP_QNAN         = 32'h7FC0_0000;
    localparam int          DEF_NUM_REQ     = 4;
    localparam int          DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/fp_add_share_ctrl_arb.sv
// Combinational round-robin arbiter.
// Picks the first set bit of req at or after ptr, wrapping from NUM_REQ-1 to 0.
// Ports:
//   req      in   NUM_REQ  request vector
//   ptr      in   IDW      highest-priority index this cycle (0..NUM_REQ-1)
//   gnt      out  NUM_REQ  one-hot grant, all zero when req is empty
//   gnt_idx  out  IDW      encoded index of the granted requester
//   gnt_any  out  1        a grant was made
module rr_arbiter
    import fp_add_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        // Walk the requesters starting at ptr; the first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_add_share_ctrl.sv
// Shares one sequential IEEE-754 single-precision adder between NUM_REQ
// requesters. A round-robin arbiter picks a requester in IDLE, its operands
// are latched and the adder is started; the sum is returned with the
// requester id once the adder reports valid.
// FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature macro: FP_ADD_SHARE_WDOG_EN adds a WAIT-state watchdog that
// aborts after TIMEOUT_CYC cycles with rsp_err=1, rsp_data=qNaN and a sticky
// timeout_err. Without it rsp_err and timeout_err are tied low.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (ready one-hot, IDLE only)
//   req_a, req_b         packed operands, slice i belongs to requester i
//   rsp_valid            one-hot one-cycle result strobe
//   rsp_id, rsp_data     answered requester index and sum
//   rsp_err              result invalid (watchdog abort)
//   add_strt             one-cycle adder start pulse
//   add_in1, add_in2     latched operands, held from ISSUE through RESP
//   add_busy             adder status, informational only
//   add_valid, add_out   adder result strobe and value
//   timeout_err          sticky watchdog flag
module fp_add_share_ctrl
    import fp_add_share_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int WIDTH       = 32,
    parameter int IDW         = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     add_strt,
    output logic [WIDTH-1:0]         add_in1,
    output logic [WIDTH-1:0]         add_in2,
    input  logic                     add_busy,
    input  logic                     add_valid,
    input  logic [WIDTH-1:0]         add_out,
    output logic                     timeout_err
);

    state_t             state, state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     ptr_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic               accept;
    logic               finish;
    logic               wdog_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The grant is only offered while idle; it already implies req_valid.
    assign req_ready = (state == ST_IDLE) ? gnt : '0;
    assign accept    = (state == ST_IDLE) && gnt_any;
    assign finish    = (state == ST_WAIT) && (add_valid || wdog_hit);
    assign ptr_nxt   = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // add_busy is status only; sequencing follows add_valid.
    logic unused_ok;
    assign unused_ok = add_busy ^ (TIMEOUT_CYC > 0);

`ifdef FP_ADD_SHARE_WDOG_EN
    localparam int WCW = $clog2(TIMEOUT_CYC + 1);

    logic [WCW-1:0] wdog_cnt;

    // A result arriving on the last budget cycle still wins over the abort.
    assign wdog_hit = (state == ST_WAIT) && !add_valid &&
                      (wdog_cnt == WCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt    <= '0;
            rsp_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wdog_cnt <= (state == ST_WAIT) ? wdog_cnt + 1'b1 : '0;
            rsp_err  <= wdog_hit;
            if (wdog_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit    = 1'b0;
    assign rsp_err     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (finish) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            add_in1   <= '0;
            add_in2   <= '0;
            add_strt  <= 1'b0;
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            // Strobes default low; each is high for exactly one state.
            add_strt  <= accept;
            rsp_valid <= '0;
            // Accept: latch winner operands and advance the priority pointer.
            if (accept) begin
                add_in1 <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                add_in2 <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                id_q    <= gnt_idx;
                rr_ptr  <= ptr_nxt;
            end
            // WAIT -> RESP: capture the sum (or qNaN on abort) for the RESP cycle.
            if (finish) begin
                rsp_valid <= NUM_REQ'(1) << id_q;
                rsp_id    <= id_q;
                rsp_data  <= wdog_hit ? WIDTH'(FP_QNAN) : add_out;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_share_ctrl.sv
module tb_fp_add_share_ctrl;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              add_strt;
    logic [31:0]       add_in1;
    logic [31:0]       add_in2;
    logic              add_busy;
    logic              add_valid;
    logic [31:0]       add_out;
    logic              timeout_err;

    fp_add_share_ctrl #(
        .NUM_REQ     (NREQ),
        .WIDTH       (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .add_strt    (add_strt),
        .add_in1     (add_in1),
        .add_in2     (add_in2),
        .add_busy    (add_busy),
        .add_valid   (add_valid),
        .add_out     (add_out),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // IEEE single <-> real conversion for exactly representable values.
    function automatic real f2r(logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        v = real'({1'b1, b[22:0]});
        e = int'(b[30:23]) - 150;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] f;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e), f};
    endfunction

    function automatic logic [31:0] rand_fp();
        int v;
        v = int'($urandom_range(0, 2000)) - 1000;
        return r2f(real'(v));
    endfunction

    // Stub sequential adder: sum appears 1..6 cycles after the start pulse.
    logic        stub_valid = 1'b0;
    logic        inj_valid  = 1'b0;
    bit          stub_stall = 1'b0;
    int          stub_cnt   = 0;
    assign add_valid = stub_valid | inj_valid;
    assign add_busy  = (stub_cnt != 0);

    initial begin
        add_out = '0;
        forever begin
            @(negedge clk);
            stub_valid = 1'b0;
            if (rst) begin
                stub_cnt = 0;
            end else begin
                if (stub_cnt > 0) begin
                    stub_cnt--;
                    if (stub_cnt == 0) stub_valid = 1'b1;
                end
                if (add_strt && !stub_stall) begin
                    stub_cnt = int'($urandom_range(1, 6));
                    add_out  = r2f(f2r(add_in1) + f2r(add_in2));
                end
            end
        end
    end

    // Reference model: pending requests, priority pointer, outstanding result.
    typedef struct { int id; logic [31:0] data; logic err; } exp_t;
    typedef struct { int id; logic [31:0] data; } rsp_t;

    logic [NREQ-1:0] pv = '0;
    logic [31:0]     pa [NREQ];
    logic [31:0]     pb [NREQ];
    int              mptr = 0;
    bit              inflight = 0;
    bit              resp_seen = 0;
    logic [31:0]     exp_a, exp_b;
    exp_t            q[$];
    int              acc_log[$];
    rsp_t            rsp_log[$];
    int              cyc = 0;
    int              strt_cyc = 0;
    int              rsp_cyc = 0;

    function automatic logic [NREQ-1:0] model_pick();
        int i;
        for (int k = 0; k < NREQ; k++) begin
            i = (mptr + k) % NREQ;
            if (pv[i]) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    task automatic drive();
        req_valid = pv;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = pa[i];
            req_b[i*32 +: 32] = pb[i];
        end
    endtask

    task automatic cycle();
        logic [NREQ-1:0] exp_gnt;
        int              gi;
        bit              acc;
        exp_t            e;
        drive();
        #1;
        exp_gnt = inflight ? '0 : model_pick();
        chk("req_ready", 32'(req_ready), 32'(exp_gnt));
        if (resp_seen) begin
            inflight  = 0;
            resp_seen = 0;
        end
        acc = 0;
        if (exp_gnt != '0) begin
            gi = 0;
            for (int i = 0; i < NREQ; i++) if (exp_gnt[i]) gi = i;
            acc      = 1;
            inflight = 1;
            exp_a    = pa[gi];
            exp_b    = pb[gi];
            q.push_back('{gi, r2f(f2r(pa[gi]) + f2r(pb[gi])), 1'b0});
            acc_log.push_back(gi);
            mptr   = (gi + 1) % NREQ;
            pv[gi] = 1'b0;
        end
        @(negedge clk);
        cyc++;
        chk("add_strt", 32'(add_strt), 32'(acc));
        if (acc) strt_cyc = cyc;
        if (inflight) begin
            chk("add_in1", add_in1, exp_a);
            chk("add_in2", add_in2, exp_b);
        end
        if (rsp_valid != '0) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                rsp_log.push_back('{int'(rsp_id), rsp_data});
            end
            resp_seen = 1;
            rsp_cyc   = cyc;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((inflight || q.size() != 0 || pv != '0) && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_budget", 32'(q.size()), 32'h0);
        q.delete();
        inflight  = 0;
        resp_seen = 0;
        pv        = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pv  = '0;
        drive();
        inflight  = 0;
        resp_seen = 0;
        mptr      = 0;
        q.delete();
        @(negedge clk);
        cyc++;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_add_strt", 32'(add_strt), 32'h0);
        chk("rst_add_in1", add_in1, 32'h0);
        chk("rst_add_in2", add_in2, 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0;
        int n;
        for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; end

        // 1. Single requester
        do_reset();
        n0 = rsp_log.size();
        pa[0] = 32'h3F80_0000; pb[0] = 32'h4000_0000; pv[0] = 1'b1;
        wait_done(50);
        chk("t1_count", 32'(rsp_log.size() - n0), 32'd1);
        if (rsp_log.size() > n0) begin
            chk("t1_id", 32'(rsp_log[n0].id), 32'd0);
            chk("t1_data", rsp_log[n0].data, 32'h4040_0000);
        end

        // 2. Two simultaneous requesters from reset
        do_reset();
        n0 = rsp_log.size();
        pa[1] = 32'h3FC0_0000; pb[1] = 32'hBF00_0000;
        pa[2] = 32'h4040_0000; pb[2] = 32'hBF80_0000;
        pv[1] = 1'b1; pv[2] = 1'b1;
        wait_done(100);
        chk("t2_count", 32'(rsp_log.size() - n0), 32'd2);
        if (rsp_log.size() >= n0 + 2) begin
            chk("t2_first_id", 32'(rsp_log[n0].id), 32'd1);
            chk("t2_first_data", rsp_log[n0].data, 32'h3F80_0000);
            chk("t2_second_id", 32'(rsp_log[n0+1].id), 32'd2);
            chk("t2_second_data", rsp_log[n0+1].data, 32'h4000_0000);
        end

        // 3. All four held valid for 8 operations
        do_reset();
        n0 = acc_log.size();
        n  = 0;
        while (acc_log.size() < n0 + 8 && n < 200) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin pa[i] = rand_fp(); pb[i] = rand_fp(); end
            end
            pv = '1;
            cycle();
            n++;
        end
        pv = '0;
        wait_done(50);
        chk("t3_grants", 32'(acc_log.size() - n0), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (acc_log.size() > n0 + k) chk("t3_order", 32'(acc_log[n0+k]), 32'(k % 4));
        end

        // 4. Reset while waiting on the adder
        do_reset();
        stub_stall = 1'b1;
        pa[0] = rand_fp(); pb[0] = rand_fp(); pv[0] = 1'b1;
        cycle(); cycle(); cycle();
        do_reset();
        stub_stall = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        n0 = acc_log.size();
        pa[0] = rand_fp(); pb[0] = rand_fp();
        pa[3] = rand_fp(); pb[3] = rand_fp();
        pv[0] = 1'b1; pv[3] = 1'b1;
        cycle();
        chk("t4_accepted", 32'(acc_log.size() - n0), 32'd1);
        if (acc_log.size() > n0) chk("t4_first_grant", 32'(acc_log[n0]), 32'd0);
        wait_done(100);
        if (acc_log.size() > n0 + 1) chk("t4_second_grant", 32'(acc_log[n0+1]), 32'd3);

        // 6. Stray adder strobe while idle
        inj_valid = 1'b1;
        cycle();
        inj_valid = 1'b0;
        cycle();
        chk("t6_rsp_valid", 32'(rsp_valid), 32'h0);
        n0 = acc_log.size();
        pa[2] = rand_fp(); pb[2] = rand_fp(); pv[2] = 1'b1;
        cycle();
        chk("t6_idle_accept", 32'(acc_log.size() - n0), 32'd1);
        wait_done(50);

`ifdef FP_ADD_SHARE_WDOG_EN
        // 5. Watchdog abort with an adder that never answers
        do_reset();
        stub_stall = 1'b1;
        pa[1] = rand_fp(); pb[1] = rand_fp(); pv[1] = 1'b1;
        cycle();
        if (q.size() > 0) begin
            q[0].data = 32'h7FC0_0000;
            q[0].err  = 1'b1;
        end
        wait_done(60);
        chk("t5_latency", 32'(rsp_cyc - strt_cyc), 32'd17);
        chk("t5_timeout_err", 32'(timeout_err), 32'd1);
        inj_valid = 1'b1;
        cycle();
        inj_valid = 1'b0;
        cycle(); cycle();
        chk("t5_timeout_sticky", 32'(timeout_err), 32'd1);
        stub_stall = 1'b0;
`endif

        // Randomized traffic with random arrivals and withdrawals
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pa[i] = rand_fp(); pb[i] = rand_fp(); pv[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            cycle();
        end
        wait_done(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
